// File: rtl/fb_bank_ctrl_if.sv
// fb_bank_ctrl_if: camera/display pulses in, bank selection and statistics out.
interface fb_bank_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
);
    logic                  wr_fstart;
    logic                  wr_lend;
    logic                  wr_fend;
    logic                  rd_fstart;
    logic                  freeze;
    logic                  wr_bank;
    logic                  rd_bank;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_row;
    logic                  swap;
    logic [CNT_WIDTH-1:0]  drop_cnt;
    logic [CNT_WIDTH-1:0]  repeat_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;

    modport master (
        output wr_fstart, wr_lend, wr_fend, rd_fstart, freeze,
        input  wr_bank, rd_bank, wr_en, wr_row, swap, drop_cnt, repeat_cnt, err_cnt
    );

    modport slave (
        input  wr_fstart, wr_lend, wr_fend, rd_fstart, freeze,
        output wr_bank, rd_bank, wr_en, wr_row, swap, drop_cnt, repeat_cnt, err_cnt
    );
endinterface

// File: rtl/fb_bank_ctrl.sv
// fb_bank_ctrl: double-buffer bank arbiter between a camera writer and a display reader.
// Define FB_BANK_CTRL_STATS_EN to implement the drop/repeat/error counters.
module fb_bank_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int VACT       = 480,
    parameter int CNT_WIDTH  = 8
) (
    input logic           clk,
    input logic           rst_n,
    fb_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITING, FULL} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VACT - 1);

    state_t                state, state_nx;
    logic                  bank, bank_nx;
    logic                  en, en_nx;
    logic                  over, over_nx;
    logic                  swap, swap_nx;
    logic [ADDR_WIDTH-1:0] row, row_nx;
    logic                  inc_drop, inc_rep, inc_err;

    always_comb begin
        state_nx = state;
        bank_nx  = bank;
        en_nx    = en;
        over_nx  = over;
        row_nx   = row;
        swap_nx  = 1'b0;
        inc_drop = 1'b0;
        inc_rep  = 1'b0;
        inc_err  = 1'b0;
        // The swap is resolved first so a same-cycle frame start writes the new bank.
        if (bus.rd_fstart && !bus.freeze) begin
            if (state == FULL) begin
                bank_nx  = ~bank;
                swap_nx  = 1'b1;
                state_nx = IDLE;
            end else begin
                inc_rep = 1'b1;
            end
        end
        if (bus.wr_fstart) begin
            inc_err  = state == WRITING;
            inc_drop = state_nx == FULL;
            state_nx = WRITING;
            row_nx   = '0;
            en_nx    = 1'b1;
            over_nx  = 1'b0;
        end else if (state == WRITING && bus.wr_fend) begin
            state_nx = (!en && !over) ? FULL : IDLE;
            inc_err  = en || over;
            en_nx    = 1'b0;
        end else if (state == WRITING && bus.wr_lend) begin
            // en low with lines still arriving means the frame is overlong
            if (!en)
                over_nx = 1'b1;
            else if (row == LAST)
                en_nx = 1'b0;
            else
                row_nx = row + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bank  <= 1'b1;
            en    <= 1'b0;
            over  <= 1'b0;
            row   <= '0;
            swap  <= 1'b0;
        end else begin
            state <= state_nx;
            bank  <= bank_nx;
            en    <= en_nx;
            over  <= over_nx;
            row   <= row_nx;
            swap  <= swap_nx;
        end
    end

    assign bus.wr_bank = bank;
    assign bus.rd_bank = ~bank;
    assign bus.wr_en   = en;
    assign bus.wr_row  = row;
    assign bus.swap    = swap;

`ifdef FB_BANK_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] drop_c, rep_c, err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_c <= '0;
            rep_c  <= '0;
            err_c  <= '0;
        end else begin
            if (inc_drop && !(&drop_c)) drop_c <= drop_c + CNT_WIDTH'(1);
            if (inc_rep && !(&rep_c))   rep_c  <= rep_c + CNT_WIDTH'(1);
            if (inc_err && !(&err_c))   err_c  <= err_c + CNT_WIDTH'(1);
        end
    end

    assign bus.drop_cnt   = drop_c;
    assign bus.repeat_cnt = rep_c;
    assign bus.err_cnt    = err_c;
`else
    logic unused_stats;
    assign unused_stats   = inc_drop ^ inc_rep ^ inc_err;
    assign bus.drop_cnt   = '0;
    assign bus.repeat_cnt = '0;
    assign bus.err_cnt    = '0;
`endif
endmodule

// File: doc/fb_bank_ctrl.md
FB_BANK_CTRL -- requirements
Module: fb_bank_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, 10, width of line counter and oWR_ROW.
REQ-002 Parameter VACT, 480, lines per complete camera frame.
REQ-003 Parameter CNT_WIDTH, 8, width of statistics counters.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 iWR_FSTART  input  1  one-cycle pulse, camera frame start, pre-synchronized to CLK.
REQ-007 iWR_LEND  input  1  one-cycle pulse, camera line written.
REQ-008 iWR_FEND  input  1  one-cycle pulse, camera frame end.
REQ-009 iRD_FSTART  input  1  one-cycle pulse, display frame start (vsync leading edge).
REQ-010 iFREEZE  input  1  level; 1 suppresses bank swaps.
REQ-011 oWR_BANK  output  1  bank written by camera.
REQ-012 oRD_BANK  output  1  bank read by display; always equals ~oWR_BANK.
REQ-013 oWR_EN  output  1  write enable to selected bank.
REQ-014 oWR_ROW  output  ADDR_WIDTH  current write line address.
REQ-015 oSWAP  output  1  one-cycle pulse, banks exchanged.
REQ-016 oDROP_CNT  output  CNT_WIDTH  frames lost before display.
REQ-017 oREPEAT_CNT  output  CNT_WIDTH  display frames reusing old bank.
REQ-018 oERR_CNT  output  CNT_WIDTH  truncated or overlong camera frames.

Function
REQ-019 States IDLE, WRITING, FULL; all outputs registered, one-cycle latency from input pulse.
REQ-020 IDLE/FULL + iWR_FSTART -> WRITING, oWR_ROW<=0, oWR_EN<=1.
REQ-021 WRITING + iWR_LEND -> oWR_ROW+1; at oWR_ROW==VACT-1, oWR_EN<=0, row holds.
REQ-022 WRITING + iWR_FEND with VACT lines counted -> FULL (pending frame).
REQ-023 WRITING + iWR_FEND with line count != VACT -> IDLE, oERR_CNT+1, frame discarded.
REQ-024 WRITING + iWR_FSTART (missing end) -> restart WRITING, row 0, oERR_CNT+1.
REQ-025 iWR_LEND beyond VACT lines -> ignored for address, frame flagged overlong, counted at iWR_FEND per REQ-023.
REQ-026 FULL + iWR_FSTART without same-cycle swap -> pending frame overwritten, oDROP_CNT+1, WRITING.
REQ-027 FULL + iRD_FSTART + iFREEZE=0 -> toggle both banks, oSWAP=1, -> IDLE.
REQ-028 iRD_FSTART in IDLE or WRITING with iFREEZE=0 -> no swap, oREPEAT_CNT+1.
REQ-029 iRD_FSTART with iFREEZE=1 -> no swap, no count; FULL retained.
REQ-030 Same-cycle FULL + iRD_FSTART + iWR_FSTART -> swap first, then WRITING into new oWR_BANK, no drop.
REQ-031 Same-cycle iWR_FEND + iRD_FSTART -> FULL entered, no swap, oREPEAT_CNT+1.
REQ-032 All counters saturate at all-ones, never wrap.
REQ-033 oWR_BANK never changes while oWR_EN=1.

Reset
REQ-034 RST_N low -> state IDLE, oWR_BANK=1, oRD_BANK=0, oWR_EN=0, oWR_ROW=0, oSWAP=0, all counters 0, immediately and asynchronously.
REQ-035 Reset mid-frame discards partial frame; first operation after release needs a fresh iWR_FSTART.

Configuration
REQ-036 Macro FB_BANK_CTRL_STATS_EN defined -> oDROP_CNT, oREPEAT_CNT, oERR_CNT implemented per REQ-016..018.
REQ-037 Macro undefined -> counter registers absent, the three outputs tied constant 0; all other behaviour identical.

Verification
REQ-038 VACT=4: reset, FSTART, 4 LEND, FEND, RD_FSTART -> oSWAP pulse, oWR_BANK=0, oRD_BANK=1.
REQ-039 Complete frame, then FSTART before RD_FSTART -> oDROP_CNT=1, banks unchanged, oWR_EN=1.
REQ-040 FSTART, 3 LEND, FEND (VACT=4) -> oERR_CNT=1, state IDLE; then RD_FSTART -> oREPEAT_CNT=1, no swap.
REQ-041 FULL, RD_FSTART and FSTART same cycle -> oSWAP=1, oWR_BANK toggled, oWR_EN=1, oDROP_CNT=0.
REQ-042 FULL, iFREEZE=1, 3x RD_FSTART -> no swap, counters 0; iFREEZE=0, RD_FSTART -> swap.
REQ-043 CNT_WIDTH=2, 5 drops -> oDROP_CNT=3; macro undefined build -> all counters read 0.
